// File: rtl/snes_pad_responder.sv
// SNES controller emulation: answers the console's latch/clock polling on two ports with
// button state, including per-button autofire shared across both ports.
module snes_pad_responder #(
    parameter int unsigned TURBO_LATCHES = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        JOY_STRB,
    input  logic        JOY1_CLK,
    input  logic        JOY2_CLK,
    input  logic [11:0] BTN1,
    input  logic [11:0] BTN2,
    input  logic [11:0] TURBO1,
    input  logic [11:0] TURBO2,
    input  logic        CONN1,
    input  logic        CONN2,
    output logic        JOY1_DI,
    output logic        JOY2_DI
);

    localparam logic [7:0] TurboLatches = 8'(TURBO_LATCHES);

    // [0],[1] synchronizer stages, [2] delay flop for edge detection
    logic [2:0]       strb_q;
    logic [1:0][2:0]  pclk_q;

    logic [1:0][15:0] shreg_q, shreg_d;
    logic [1:0][4:0]  bitcnt_q, bitcnt_d;
    logic [1:0]       di_q, di_d;
    logic [7:0]       latch_cnt_q, latch_cnt_d;
    logic             phase_q, phase_d;

    logic             strb_hi, strb_fall;
    logic [1:0]       pclk_rise;
    logic [1:0][11:0] btn, turbo;
    logic [1:0]       conn;
    logic [1:0][15:0] word;

    assign btn   = {BTN2, BTN1};
    assign turbo = {TURBO2, TURBO1};
    assign conn  = {CONN2, CONN1};

    assign strb_hi   = strb_q[1];
    assign strb_fall = strb_q[2] & ~strb_q[1];
    assign pclk_rise = {pclk_q[1][1] & ~pclk_q[1][2], pclk_q[0][1] & ~pclk_q[0][2]};

    always_comb begin
        latch_cnt_d = latch_cnt_q;
        phase_d     = phase_q;
        if (strb_fall) begin
            if (latch_cnt_q + 8'd1 == TurboLatches) begin
                latch_cnt_d = 8'd0;
                phase_d     = ~phase_q;
            end else begin
                latch_cnt_d = latch_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        word     = '0;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        di_d     = '1;
        for (int p = 0; p < 2; p++) begin
            word[p] = {4'b0000, btn[p] & ~(turbo[p] & {12{phase_q}})};
            if (strb_hi) begin
                shreg_d[p]  = word[p];
                bitcnt_d[p] = 5'd0;
            end else if (pclk_rise[p]) begin
                shreg_d[p] = {1'b1, shreg_q[p][15:1]};
                if (bitcnt_q[p] != 5'd16) begin
                    bitcnt_d[p] = bitcnt_q[p] + 5'd1;
                end
            end
            // Driven from next-state so the pin follows on the same edge the shift happens
            di_d[p] = conn[p] ? ~shreg_d[p][0] : 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            strb_q      <= 3'b000;
            pclk_q      <= {3'b111, 3'b111};
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            di_q        <= 2'b11;
            latch_cnt_q <= 8'd0;
            phase_q     <= 1'b0;
        end else begin
            strb_q      <= {strb_q[1:0], JOY_STRB};
            pclk_q[0]   <= {pclk_q[0][1:0], JOY1_CLK};
            pclk_q[1]   <= {pclk_q[1][1:0], JOY2_CLK};
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            di_q        <= di_d;
            latch_cnt_q <= latch_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign JOY1_DI = di_q[0];
    assign JOY2_DI = di_q[1];

endmodule

// File: tb/tb_snes_pad_responder.sv
// Self-checking bench for snes_pad_responder: scoreboard of expected serial bits per readout,
// plus latency, strobe-hold, autofire, disconnect and mid-readout reset scenarios.
module tb_snes_pad_responder;

    localparam int TL = 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        JOY_STRB, JOY1_CLK, JOY2_CLK;
    logic [11:0] BTN1, BTN2, TURBO1, TURBO2;
    logic        CONN1, CONN2;
    logic        JOY1_DI, JOY2_DI;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic phase_m;
    int   cnt_m;

    typedef struct {
        int   port;
        int   idx;
        logic exp;
        logic obs;
    } ent_t;

    ent_t sb[$];

    snes_pad_responder #(.TURBO_LATCHES(TL)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .JOY_STRB(JOY_STRB),
        .JOY1_CLK(JOY1_CLK),
        .JOY2_CLK(JOY2_CLK),
        .BTN1    (BTN1),
        .BTN2    (BTN2),
        .TURBO1  (TURBO1),
        .TURBO2  (TURBO2),
        .CONN1   (CONN1),
        .CONN2   (CONN2),
        .JOY1_DI (JOY1_DI),
        .JOY2_DI (JOY2_DI)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic model_reset();
        phase_m = 1'b0;
        cnt_m   = 0;
    endtask

    task automatic model_fall();
        cnt_m++;
        if (cnt_m == TL) begin
            cnt_m   = 0;
            phase_m = ~phase_m;
        end
    endtask

    function automatic logic exp_di(input logic [15:0] w, input int k, input logic conn);
        logic bitv;
        bitv = (k < 16) ? w[k] : 1'b1;
        return conn ? ~bitv : 1'b1;
    endfunction

    task automatic push(input int port, input int idx, input logic exp, input logic obs);
        ent_t e;
        e.port = port;
        e.idx  = idx;
        e.exp  = exp;
        e.obs  = obs;
        sb.push_back(e);
    endtask

    // Latch, then np1 clocks on port 1, then np2 clocks on port 2; record expected vs seen bits.
    task automatic frame(input logic [11:0] b1, input logic [11:0] t1, input logic [11:0] b2,
                         input logic [11:0] t2, input int np1, input int np2);
        logic [15:0] w1, w2;
        BTN1 = b1; TURBO1 = t1; BTN2 = b2; TURBO2 = t2;
        w1 = {4'b0000, b1 & ~(t1 & {12{phase_m}})};
        w2 = {4'b0000, b2 & ~(t2 & {12{phase_m}})};
        JOY_STRB = 1'b1;
        cyc(4);
        JOY_STRB = 1'b0;
        model_fall();
        cyc(4);
        push(1, 0, exp_di(w1, 0, CONN1), JOY1_DI);
        push(2, 0, exp_di(w2, 0, CONN2), JOY2_DI);
        for (int k = 1; k <= np1; k++) begin
            JOY1_CLK = 1'b0;
            cyc(4);
            JOY1_CLK = 1'b1;
            cyc(4);
            push(1, k, exp_di(w1, k, CONN1), JOY1_DI);
            push(2, 0, exp_di(w2, 0, CONN2), JOY2_DI);
        end
        for (int k = 1; k <= np2; k++) begin
            JOY2_CLK = 1'b0;
            cyc(4);
            JOY2_CLK = 1'b1;
            cyc(4);
            push(2, k, exp_di(w2, k, CONN2), JOY2_DI);
            push(1, np1, exp_di(w1, np1, CONN1), JOY1_DI);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        JOY_STRB = 1'b0; JOY1_CLK = 1'b1; JOY2_CLK = 1'b1;
        BTN1 = '0; BTN2 = '0; TURBO1 = '0; TURBO2 = '0;
        CONN1 = 1'b1; CONN2 = 1'b1;
        cyc(3);
        total_cnt++;
        if ({JOY1_DI, JOY2_DI} !== 2'b11)
            $display("FAIL reset_di: got %b want 11", {JOY1_DI, JOY2_DI});
        else pass_cnt++;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            total_cnt++;
            if ({JOY1_DI, JOY2_DI} !== 2'b11)
                $display("FAIL post_reset_idle cyc%0d: got %b want 11", i, {JOY1_DI, JOY2_DI});
            else pass_cnt++;
        end
    endtask

    task automatic test_readout_p1();
        ent_t e;
        frame(12'h001, 12'h000, 12'h000, 12'h000, 17, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (e.obs !== e.exp)
                $display("FAIL readout_p1 port%0d bit%0d: got %b want %b", e.port, e.idx, e.obs,
                         e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_readout_p2();
        ent_t e;
        frame(12'h001, 12'h000, 12'h800, 12'h000, 0, 16);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (e.obs !== e.exp)
                $display("FAIL readout_p2 port%0d bit%0d: got %b want %b", e.port, e.idx, e.obs,
                         e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_strobe_held();
        ent_t e;
        BTN1 = 12'h001; TURBO1 = '0;
        JOY_STRB = 1'b1;
        cyc(4);
        for (int i = 0; i < 6; i++) begin
            JOY1_CLK = ~JOY1_CLK;
            cyc(4);
            push(1, 0, 1'b0, JOY1_DI);
        end
        BTN1 = 12'h000;
        cyc(1);
        push(1, 0, 1'b1, JOY1_DI);
        BTN1 = 12'h001;
        cyc(1);
        push(1, 0, 1'b0, JOY1_DI);
        JOY_STRB = 1'b0;
        model_fall();
        cyc(4);
        push(1, 0, 1'b0, JOY1_DI);
        JOY1_CLK = 1'b0;
        cyc(4);
        JOY1_CLK = 1'b1;
        cyc(4);
        push(1, 1, 1'b1, JOY1_DI);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (e.obs !== e.exp)
                $display("FAIL strobe_held port%0d bit%0d: got %b want %b", e.port, e.idx, e.obs,
                         e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_turbo();
        ent_t e;
        logic want8;
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        model_reset();
        cyc(2);
        for (int f = 0; f < 8; f++) begin
            frame(12'h100, 12'h100, 12'h000, 12'h000, 16, 0);
            want8 = ((f / 2) % 2 == 0) ? 1'b0 : 1'b1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                total_cnt++;
                if (e.obs !== e.exp)
                    $display("FAIL turbo frame%0d port%0d bit%0d: got %b want %b", f, e.port,
                             e.idx, e.obs, e.exp);
                else pass_cnt++;
                if (e.port == 1 && e.idx == 8) begin
                    total_cnt++;
                    if (e.obs !== want8)
                        $display("FAIL turbo_pattern frame%0d: got %b want %b", f, e.obs, want8);
                    else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_conn_and_reset();
        ent_t e;
        CONN1 = 1'b0;
        frame(12'hfff, 12'h000, 12'h000, 12'h000, 16, 0);
        CONN1 = 1'b1;
        BTN1 = 12'hfff;
        JOY_STRB = 1'b1;
        cyc(4);
        JOY_STRB = 1'b0;
        model_fall();
        cyc(4);
        for (int k = 1; k <= 5; k++) begin
            JOY1_CLK = 1'b0;
            cyc(4);
            JOY1_CLK = 1'b1;
            cyc(4);
        end
        push(1, 5, 1'b0, JOY1_DI);
        reset = 1'b1;
        cyc(1);
        push(1, 99, 1'b1, JOY1_DI);
        model_reset();
        cyc(1);
        reset = 1'b0;
        cyc(2);
        frame(12'h001, 12'h000, 12'h000, 12'h000, 2, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (e.obs !== e.exp)
                $display("FAIL conn_reset port%0d bit%0d: got %b want %b", e.port, e.idx, e.obs,
                         e.exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_latency_same_cycle();
        ent_t e;
        frame(12'h001, 12'h000, 12'h000, 12'h000, 0, 0);
        JOY1_CLK = 1'b0;
        cyc(4);
        JOY1_CLK = 1'b1;
        cyc(1);
        push(1, 101, 1'b0, JOY1_DI);
        cyc(1);
        push(1, 102, 1'b0, JOY1_DI);
        cyc(1);
        push(1, 103, 1'b1, JOY1_DI);
        cyc(2);
        JOY1_CLK = 1'b0;
        cyc(4);
        JOY_STRB = 1'b1;
        JOY1_CLK = 1'b1;
        cyc(4);
        JOY_STRB = 1'b0;
        model_fall();
        cyc(4);
        push(1, 0, 1'b0, JOY1_DI);
        JOY1_CLK = 1'b0;
        cyc(4);
        JOY1_CLK = 1'b1;
        cyc(4);
        push(1, 1, 1'b1, JOY1_DI);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total_cnt++;
            if (e.obs !== e.exp)
                $display("FAIL latency port%0d step%0d: got %b want %b", e.port, e.idx, e.obs,
                         e.exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_readout_p1();
        test_readout_p2();
        test_strobe_held();
        test_latency_same_cycle();
        test_conn_and_reset();
        test_turbo();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
